// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the pipelined datapath.
//   op_e         ALU opcode encodings (8-bit)
//   FLG_*        bit positions inside the 5-bit flag vector {N,Z,F,L,C}
//   op_writes()  true for opcodes whose result may be written back
package dp_pkg;

   typedef enum logic [7:0] {
      OP_AND = 8'h01,
      OP_OR  = 8'h02,
      OP_XOR = 8'h03,
      OP_ADD = 8'h05,
      OP_SUB = 8'h09,
      OP_CMP = 8'h0B,
      OP_MOV = 8'h0D
   } op_e;

   localparam int FLG_C = 0;
   localparam int FLG_L = 1;
   localparam int FLG_F = 2;
   localparam int FLG_Z = 3;
   localparam int FLG_N = 4;

   localparam int FLAG_W = 5;

   // CMP and unlisted opcodes never write the register file.
   function automatic logic op_writes(input logic [7:0] op);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MOV: op_writes = 1'b1;
         default:                                      op_writes = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dp_alu.sv
// dp_alu: purely combinational ALU for the datapath EX stage.
//   a, b        operands (a = destination register, b = source/immediate)
//   op          opcode (dp_pkg encodings)
//   result      ALU result, wrap-around at DATA_W bits
//   flag_val    new flag values {N,Z,F,L,C}
//   flag_mask   1 for each flag this op updates; others must hold
module dp_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [7:0]        op,
   output logic [DATA_W-1:0] result,
   output logic [FLAG_W-1:0] flag_val,
   output logic [FLAG_W-1:0] flag_mask
);

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = a - b;

   always_comb begin
      result    = '0;
      flag_val  = '0;
      flag_mask = '0;
      case (op)
         OP_ADD: begin
            result           = sum[DATA_W-1:0];
            flag_val[FLG_C]  = sum[DATA_W];
            // signed overflow: like-signed operands giving a differently-signed sum
            flag_val[FLG_F]  = (a[DATA_W-1] == b[DATA_W-1]) &&
                               (sum[DATA_W-1] != a[DATA_W-1]);
            flag_val[FLG_Z]  = (sum[DATA_W-1:0] == '0);
            flag_mask[FLG_C] = 1'b1;
            flag_mask[FLG_F] = 1'b1;
            flag_mask[FLG_Z] = 1'b1;
         end
         OP_SUB: begin
            result           = diff;
            flag_val[FLG_C]  = (a < b);
            // signed overflow: unlike-signed operands, result sign differs from a
            flag_val[FLG_F]  = (a[DATA_W-1] != b[DATA_W-1]) &&
                               (diff[DATA_W-1] != a[DATA_W-1]);
            flag_val[FLG_Z]  = (diff == '0);
            flag_mask[FLG_C] = 1'b1;
            flag_mask[FLG_F] = 1'b1;
            flag_mask[FLG_Z] = 1'b1;
         end
         OP_CMP: begin
            // result shows the difference for observation; it is never written back
            result           = diff;
            flag_val[FLG_Z]  = (a == b);
            flag_val[FLG_L]  = (a < b);
            flag_val[FLG_N]  = ($signed(a) < $signed(b));
            flag_mask[FLG_Z] = 1'b1;
            flag_mask[FLG_L] = 1'b1;
            flag_mask[FLG_N] = 1'b1;
         end
         OP_AND: begin
            result           = a & b;
            flag_val[FLG_Z]  = ((a & b) == '0);
            flag_mask[FLG_Z] = 1'b1;
         end
         OP_OR: begin
            result           = a | b;
            flag_val[FLG_Z]  = ((a | b) == '0);
            flag_mask[FLG_Z] = 1'b1;
         end
         OP_XOR: begin
            result           = a ^ b;
            flag_val[FLG_Z]  = ((a ^ b) == '0);
            flag_mask[FLG_Z] = 1'b1;
         end
         OP_MOV: begin
            result = b;
         end
         default: begin
            result = '0;
         end
      endcase
   end

endmodule

// File: rtl/data_path_pipe.sv
// data_path_pipe: two-stage register-bank/ALU datapath.
//   Issue stage reads operands (with EX->issue bypass) into the EX registers;
//   the following edge writes back, updates flags and latches the result.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   issue handshake; in_ready = ~hold
//   hold                  blocks issue, EX still drains
//   opcode                ALU op (dp_pkg encodings)
//   rdest_sel, rsrc_sel   destination/first operand and second operand selects
//   imm_sel, imm_in       second operand: 0 = imm_in, 1 = reg[rsrc_sel]
//   wr_en                 write result to reg[rdest_sel]
//   result, result_valid  last completed result and its one-cycle pulse
//   flags_out             persistent flags {N,Z,F,L,C}
//   dbg_sel, dbg_data     combinational register read, no bypass
module data_path_pipe
   import dp_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              hold,
   input  logic [7:0]        opcode,
   input  logic [SEL_W-1:0]  rdest_sel,
   input  logic [SEL_W-1:0]  rsrc_sel,
   input  logic              imm_sel,
   input  logic [DATA_W-1:0] imm_in,
   input  logic              wr_en,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic [4:0]        flags_out,
   input  logic [SEL_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // EX stage
   logic              ex_valid;
   logic              ex_we;
   logic [7:0]        ex_op;
   logic [SEL_W-1:0]  ex_dest;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;

   logic [DATA_W-1:0] alu_res;
   logic [FLAG_W-1:0] alu_fval;
   logic [FLAG_W-1:0] alu_fmask;

   logic              issue;
   logic [DATA_W-1:0] rf_a, rf_b;
   logic              fwd_a, fwd_b;
   logic [DATA_W-1:0] op_a, op_b;

   function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
      sel_ok = (int'(sel) < NUM_REGS);
   endfunction

   dp_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a         (ex_a),
      .b         (ex_b),
      .op        (ex_op),
      .result    (alu_res),
      .flag_val  (alu_fval),
      .flag_mask (alu_fmask)
   );

   assign in_ready = ~hold;
   assign issue    = in_valid & ~hold;

   // ex_we already excludes CMP/NOP and out-of-range destinations, so a
   // match here always means the register is about to take alu_res.
   always_comb begin
      rf_a  = sel_ok(rdest_sel) ? regs[rdest_sel] : '0;
      rf_b  = sel_ok(rsrc_sel)  ? regs[rsrc_sel]  : '0;
      fwd_a = ex_valid & ex_we & (ex_dest == rdest_sel);
      fwd_b = ex_valid & ex_we & (ex_dest == rsrc_sel);
      op_a  = fwd_a ? alu_res : rf_a;
      op_b  = imm_sel ? (fwd_b ? alu_res : rf_b) : imm_in;
   end

   assign dbg_data = sel_ok(dbg_sel) ? regs[dbg_sel] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         ex_valid     <= 1'b0;
         ex_we        <= 1'b0;
         ex_op        <= '0;
         ex_dest      <= '0;
         ex_a         <= '0;
         ex_b         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         flags_out    <= '0;
      end else begin
         ex_valid     <= issue;
         result_valid <= ex_valid;
         if (issue) begin
            ex_a    <= op_a;
            ex_b    <= op_b;
            ex_op   <= opcode;
            ex_dest <= rdest_sel;
            ex_we   <= wr_en & op_writes(opcode) & sel_ok(rdest_sel);
         end
         if (ex_valid) begin
            result    <= alu_res;
            flags_out <= (flags_out & ~alu_fmask) | (alu_fval & alu_fmask);
            if (ex_we) begin
               regs[ex_dest] <= alu_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_path_pipe.sv
// tb_data_path_pipe: directed, scoreboard-checked bench for data_path_pipe.
//   Stimulus pushes the hand-computed result of each accepted op into a
//   queue; a monitor pops and compares on every result_valid cycle.
//   Register, flag and handshake state is checked directly via dbg port.
module tb_data_path_pipe;
   import dp_pkg::*;

   localparam int DW = 16;
   localparam int NR = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          hold;
   logic [7:0]    opcode;
   logic [SW-1:0] rdest_sel;
   logic [SW-1:0] rsrc_sel;
   logic          imm_sel;
   logic [DW-1:0] imm_in;
   logic          wr_en;
   logic [DW-1:0] result;
   logic          result_valid;
   logic [4:0]    flags_out;
   logic [SW-1:0] dbg_sel;
   logic [DW-1:0] dbg_data;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] mon_exp;

   data_path_pipe #(
      .DATA_W   (DW),
      .NUM_REGS (NR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .hold         (hold),
      .opcode       (opcode),
      .rdest_sel    (rdest_sel),
      .rsrc_sel     (rsrc_sel),
      .imm_sel      (imm_sel),
      .imm_in       (imm_in),
      .wr_en        (wr_en),
      .result       (result),
      .result_valid (result_valid),
      .flags_out    (flags_out),
      .dbg_sel      (dbg_sel),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && result_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected: got %h expected no result_valid", result);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", {16'h0, result}, {16'h0, mon_exp});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [7:0] op, input int d, input int s, input logic isel,
                        input logic [DW-1:0] imm, input logic we, input logic push,
                        input logic [DW-1:0] e);
      in_valid  = 1'b1;
      opcode    = op;
      rdest_sel = SW'(d);
      rsrc_sel  = SW'(s);
      imm_sel   = isel;
      imm_in    = imm;
      wr_en     = we;
      if (push) exp_q.push_back(e);
      step(1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      wr_en    = 1'b0;
   endtask

   task automatic chk_reg(input string name, input int r, input logic [DW-1:0] e);
      dbg_sel = SW'(r);
      #1;
      check(name, {16'h0, dbg_data}, {16'h0, e});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; hold = 1'b0; in_valid = 1'b0; opcode = '0;
      rdest_sel = '0; rsrc_sel = '0; imm_sel = 1'b0; imm_in = '0;
      wr_en = 1'b0; dbg_sel = '0;
      step(2);
      reset = 1'b0;

      // 1. reset state
      for (int i = 0; i < NR; i++) chk_reg($sformatf("reset_r%0d", i), i, 16'h0);
      check("reset_flags", {27'h0, flags_out}, 32'h0);
      check("reset_rvalid", {31'h0, result_valid}, 32'h0);
      check("reset_in_ready", {31'h0, in_ready}, 32'h1);

      // 2. back-to-back with bypass; also same-edge writeback of r1
      issue(OP_MOV, 1, 0, 1'b0, 16'd5, 1'b1, 1'b1, 16'd5);
      issue(OP_ADD, 1, 0, 1'b0, 16'd3, 1'b1, 1'b1, 16'd8);
      idle();
      step(1);
      chk_reg("bypass_r1", 1, 16'd8);

      // 3. carry/zero and signed overflow
      issue(OP_MOV, 2, 0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
      idle(); step(1);
      issue(OP_ADD, 2, 0, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0000);
      idle(); step(1);
      chk_reg("add_wrap_r2", 2, 16'h0000);
      check("add_wrap_flags", {27'h0, flags_out}, 32'h09);
      issue(OP_MOV, 3, 0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h7FFF);
      issue(OP_ADD, 3, 0, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h8000);
      idle(); step(1);
      chk_reg("add_ovf_r3", 3, 16'h8000);
      check("add_ovf_flags", {27'h0, flags_out}, 32'h04);

      // 4. CMP register form: no write, Z/L/N updated, C/F held
      issue(OP_MOV, 4, 0, 1'b0, 16'd3, 1'b1, 1'b1, 16'd3);
      issue(OP_MOV, 5, 0, 1'b0, 16'hFFFE, 1'b1, 1'b1, 16'hFFFE);
      issue(OP_CMP, 4, 5, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0005);
      idle(); step(1);
      chk_reg("cmp_r4", 4, 16'd3);
      chk_reg("cmp_r5", 5, 16'hFFFE);
      check("cmp_flags", {27'h0, flags_out}, 32'h06);

      // unlisted opcode: result 0, no write, flags held; then XOR sets Z
      issue(8'hFF, 4, 0, 1'b0, 16'd7, 1'b1, 1'b1, 16'h0000);
      issue(OP_XOR, 4, 0, 1'b0, 16'd3, 1'b1, 1'b1, 16'h0000);
      idle(); step(1);
      chk_reg("xor_r4", 4, 16'h0000);
      check("xor_flags", {27'h0, flags_out}, 32'h0E);

      // 5. hold blocks issue while EX drains
      issue(OP_MOV, 6, 0, 1'b0, 16'd9, 1'b1, 1'b1, 16'd9);
      hold = 1'b1; in_valid = 1'b1; opcode = OP_ADD; rdest_sel = 4'd6;
      imm_sel = 1'b0; imm_in = 16'd1; wr_en = 1'b1;
      #1;
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk_reg("hold_r6_a", 6, 16'd9);
      step(1);
      chk_reg("hold_r6_b", 6, 16'd9);
      hold = 1'b0;
      exp_q.push_back(16'd10);
      step(1);
      idle(); step(1);
      chk_reg("release_r6", 6, 16'd10);
      check("release_flags", {27'h0, flags_out}, 32'h02);
      step(3);

      // 6. reset during EX discards the op
      issue(OP_ADD, 7, 0, 1'b0, 16'd4, 1'b1, 1'b0, 16'h0);
      reset = 1'b1;
      idle();
      step(1);
      reset = 1'b0;
      chk_reg("rst_mid_r7", 7, 16'h0);
      chk_reg("rst_mid_r1", 1, 16'h0);
      check("rst_mid_flags", {27'h0, flags_out}, 32'h0);
      check("rst_mid_rvalid", {31'h0, result_valid}, 32'h0);
      step(3);

      check("queue_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
